// File: rtl/gray_hex_display.sv
// Gray-code capture, Gray-to-binary conversion and multiplexed common-anode hex display driver.
// Optional leading-zero blanking when GRAY_HEX_BLANK_LZ_EN is defined.
module gray_hex_display #(
    parameter int unsigned N            = 8,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16,
    localparam int unsigned DIGITS      = (N + 3) / 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      gray_in,
    input  logic              gray_valid,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an
);

    localparam int unsigned PW   = DIGITS * 4;
    localparam int unsigned CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX);
    localparam int unsigned DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0]  SEG_OFF = 7'h7F;

    typedef enum logic {SCAN = 1'b0, BLANK = 1'b1} state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [DW-1:0]     digit, digit_d;
    logic [N-1:0]      value, value_d;
    logic [DIGITS-1:0] an_d;
    logic [6:0]        seg_d;

    logic [N-1:0]      bin_c;
    logic [PW-1:0]     padded_c;
    logic [3:0]        nib_c [DIGITS];
    logic [6:0]        glyph_c;

    // Active-low gfedcba font
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        bin_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            bin_c[i] = ^(gray_in >> i);
        end
    end

    always_comb begin
        padded_c = PW'(value);
        for (int k = 0; k < int'(DIGITS); k++) begin
            nib_c[k] = padded_c[k*4 +: 4];
        end
    end

`ifdef GRAY_HEX_BLANK_LZ_EN
    logic [DIGITS-1:0] lz_c;
    logic              hz;

    // lz_c[k]: nibble k and every nibble above it are zero
    always_comb begin
        hz   = 1'b1;
        lz_c = '0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            hz      = hz & (nib_c[k] == 4'h0);
            lz_c[k] = hz;
        end
    end

    always_comb begin
        glyph_c = hex7(nib_c[digit]);
        if ((digit != '0) && lz_c[digit]) begin
            glyph_c = SEG_OFF;
        end
    end
`else
    always_comb begin
        glyph_c = hex7(nib_c[digit]);
    end
`endif

    // Next-state and next-output logic; scan timing is independent of gray_valid
    always_comb begin
        state_d = state;
        cnt_d   = cnt + CW'(1);
        digit_d = digit;
        value_d = value;
        an_d    = '1;
        seg_d   = SEG_OFF;

        if (gray_valid) begin
            value_d = bin_c;
        end

        case (state)
            SCAN: begin
                an_d  = ~(DIGITS'(1) << digit);
                seg_d = glyph_c;
                if (cnt == CW'(REFRESH_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = BLANK;
                end
            end
            BLANK: begin
                if (cnt == CW'(BLANK_CYCLES - 1)) begin
                    cnt_d   = '0;
                    digit_d = (digit == DW'(DIGITS - 1)) ? '0 : digit + DW'(1);
                    state_d = SCAN;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SCAN;
            cnt   <= '0;
            digit <= '0;
            value <= '0;
            an    <= '1;
            seg   <= SEG_OFF;
            dp    <= 1'b1;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            digit <= digit_d;
            value <= value_d;
            an    <= an_d;
            seg   <= seg_d;
            dp    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gray_hex_display.sv
// Directed bench for gray_hex_display with N=8, REFRESH_DIV=4, BLANK_CYCLES=1 (10-clock scan period).
module tb_gray_hex_display;

    localparam logic [6:0] FONT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] gray_in;
    logic       gray_valid;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;

    int         checks   = 0;
    int         failures = 0;
    int         ph       = 0;
    logic [7:0] exp_vis  = 8'h00;

    gray_hex_display #(.N(8), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid),
        .seg(seg), .dp(dp), .an(an));

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_glyph(input logic [7:0] v, input int d);
        logic [3:0] nib;
        nib = (d == 0) ? v[3:0] : v[7:4];
`ifdef GRAY_HEX_BLANK_LZ_EN
        if (d == 1 && nib == 4'h0) return 7'h7F;
`endif
        return FONT[nib];
    endfunction

    // One clock, then check an/seg/dp against the scan schedule and the visible value
    task automatic step(input string tag);
        logic [1:0] ea;
        logic [6:0] es;
        @(posedge clk);
        @(negedge clk);
        ph = (ph + 1) % 10;
        if (ph >= 1 && ph <= 4) begin
            ea = 2'b10; es = exp_glyph(exp_vis, 0);
        end else if (ph >= 6 && ph <= 9) begin
            ea = 2'b01; es = exp_glyph(exp_vis, 1);
        end else begin
            ea = 2'b11; es = 7'h7F;
        end
        checks++;
        assert (an === ea) else begin
            failures++;
            $error("FAIL %s an ph=%0d got=%b exp=%b", tag, ph, an, ea);
        end
        checks++;
        assert (seg === es) else begin
            failures++;
            $error("FAIL %s seg ph=%0d got=%b exp=%b", tag, ph, seg, es);
        end
        checks++;
        assert (dp === 1'b1) else begin
            failures++;
            $error("FAIL %s dp got=%b exp=1", tag, dp);
        end
    endtask

    task automatic run(input string tag, input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            if (toggle) gray_in = 8'($urandom);
            step(tag);
        end
    endtask

    // Strobe on the current cycle; new value reaches the outputs one edge after capture
    task automatic strobe(input string tag, input logic [7:0] g, input logic [7:0] b);
        gray_in    = g;
        gray_valid = 1'b1;
        step(tag);
        gray_valid = 1'b0;
        exp_vis    = b;
    endtask

    task automatic check_off(input string tag);
        checks++;
        assert (an === 2'b11) else begin
            failures++;
            $error("FAIL %s an got=%b exp=11", tag, an);
        end
        checks++;
        assert (seg === 7'h7F) else begin
            failures++;
            $error("FAIL %s seg got=%b exp=1111111", tag, seg);
        end
        checks++;
        assert (dp === 1'b1) else begin
            failures++;
            $error("FAIL %s dp got=%b exp=1", tag, dp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        gray_in    = 8'h00;
        gray_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_off("reset");
        rst = 1'b0;
        ph  = 0;

        // Idle scan: both digits show 0
        run("scan", 20, 1'b0);

        // 0x80 Gray -> 0xFF
        strobe("dec_ff", 8'h80, 8'hFF);
        run("dec_ff", 10, 1'b0);

        // 0x0C Gray -> 0x08
        strobe("dec_08", 8'h0C, 8'h08);
        run("dec_08", 10, 1'b0);

        // gray_in ignored without strobe
        run("hold", 30, 1'b1);

        // Strobe while FSM is in BLANK
        while (ph != 4) step("align");
        strobe("bnd", 8'h01, 8'h01);
        run("bnd", 12, 1'b0);

        // Async reset mid-slot of digit1 (cnt=2)
        while (ph != 7) step("align");
        #2 rst = 1'b1;
        #1 check_off("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_off("rst_hold");
        rst     = 1'b0;
        ph      = 0;
        exp_vis = 8'h00;
        run("post_rst", 10, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
